// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit with a small prefetch FIFO feeding decode over valid/ready.
// A redirect flushes all buffered entries and restarts fetch at redirect_pc.
module instr_fetch_queue #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [ADDR_WIDTH-1:0]      imem_addr,
   input  logic [DATA_WIDTH-1:0]      imem_data,
   input  logic                       redirect_valid,
   input  logic [ADDR_WIDTH-1:0]      redirect_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_WIDTH-1:0]      out_instr,
   output logic [ADDR_WIDTH-1:0]      out_pc,
   output logic [$clog2(DEPTH):0]     occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [ADDR_WIDTH-1:0] pc_mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] pc_mem_d [DEPTH];
   logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] instr_mem_d [DEPTH];

   logic deq;
   logic enq;
   logic full;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign out_valid = (count_q != '0) & ~redirect_valid;
   assign deq       = out_valid & out_ready;
   // A full queue still accepts when the head leaves in the same cycle.
   assign enq       = ~redirect_valid & (~full | deq);

   assign imem_addr = fetch_pc_q;
   assign out_instr = instr_mem_q[head_q];
   assign out_pc    = pc_mem_q[head_q];
   assign occupancy = count_q;

   always_comb begin
      fetch_pc_d  = fetch_pc_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
      end else begin
         if (enq) begin
            pc_mem_d[tail_q]    = fetch_pc_q;
            instr_mem_d[tail_q] = imem_data;
            tail_d              = tail_q + PTR_W'(1);
            fetch_pc_d          = fetch_pc_q + ADDR_WIDTH'(1);
         end
         if (deq) begin
            head_d = head_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q  <= RESET_PC;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         pc_mem_q    <= '{default: '0};
         instr_mem_q <= '{default: '0};
      end else begin
         fetch_pc_q  <= fetch_pc_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         pc_mem_q    <= pc_mem_d;
         instr_mem_q <= instr_mem_d;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue; memory model returns 0x1000 + low address byte.
module tb_instr_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [2:0]  occupancy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   assign imem_data = 32'h0000_1000 + {24'd0, imem_addr[7:0]};

   instr_fetch_queue #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .DEPTH(4),
      .RESET_PC(32'd0)
   ) dut (
      .clk(clk),
      .rst(rst),
      .imem_addr(imem_addr),
      .imem_data(imem_data),
      .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_instr(out_instr),
      .out_pc(out_pc),
      .occupancy(occupancy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0h want 0", out_valid); end
      n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ got %0d want 0", occupancy); end
      n_cmp++; if (out_pc !== 32'd0) begin n_err++; $display("FAIL reset_pc got %0h want 0", out_pc); end
      n_cmp++; if (out_instr !== 32'd0) begin n_err++; $display("FAIL reset_instr got %0h want 0", out_instr); end
      n_cmp++; if (imem_addr !== 32'd0) begin n_err++; $display("FAIL reset_addr got %0h want 0", imem_addr); end
      tick();
   endtask

   task automatic test_stream();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %0h want 1", i, out_valid); end
         n_cmp++; if (out_pc !== 32'(i)) begin n_err++; $display("FAIL stream_pc[%0d] got %0h want %0h", i, out_pc, i); end
         n_cmp++; if (out_instr !== 32'h1000 + 32'(i)) begin n_err++; $display("FAIL stream_instr[%0d] got %0h want %0h", i, out_instr, 32'h1000 + 32'(i)); end
         n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occupancy); end
         tick();
      end
   endtask

   task automatic test_backpressure();
      rst = 1'b1; out_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         n_cmp++; if (occupancy !== 3'((k < 4) ? k : 4)) begin n_err++; $display("FAIL bp_occ[%0d] got %0d want %0d", k, occupancy, (k < 4) ? k : 4); end
         n_cmp++; if (imem_addr !== 32'((k < 4) ? k : 4)) begin n_err++; $display("FAIL bp_addr[%0d] got %0h want %0h", k, imem_addr, (k < 4) ? k : 4); end
         n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== 32'h1000) begin
            n_err++; $display("FAIL bp_hold[%0d] got v=%0h pc=%0h instr=%0h want v=1 pc=0 instr=1000", k, out_valid, out_pc, out_instr);
         end
         tick();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'(i)) begin n_err++; $display("FAIL bp_drain[%0d] got v=%0h pc=%0h want v=1 pc=%0h", i, out_valid, out_pc, i); end
         n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL bp_drain_occ[%0d] got %0d want 4", i, occupancy); end
         tick();
      end
   endtask

   task automatic test_redirect_full();
      out_ready = 1'b0;
      @(negedge clk);
      n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL rf_pre_occ got %0d want 4", occupancy); end
      redirect_valid = 1'b1; redirect_pc = 32'h20;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rf_same_valid got %0h want 0", out_valid); end
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL rf_occ got %0d want 0", occupancy); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rf_valid got %0h want 0", out_valid); end
      n_cmp++; if (imem_addr !== 32'h20) begin n_err++; $display("FAIL rf_addr got %0h want 20", imem_addr); end
      tick();
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== 32'h1020) begin
         n_err++; $display("FAIL rf_first got v=%0h pc=%0h instr=%0h want v=1 pc=20 instr=1020", out_valid, out_pc, out_instr);
      end
      tick();
   endtask

   task automatic test_redirect_with_ready();
      @(negedge clk);
      n_cmp++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL rr_pre_occ got %0d want 2", occupancy); end
      redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rr_same_valid got %0h want 0", out_valid); end
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin n_err++; $display("FAIL rr_flush got v=%0h occ=%0d want v=0 occ=0", out_valid, occupancy); end
      tick();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h40 + 32'(i) || out_instr !== 32'h1040 + 32'(i)) begin
            n_err++; $display("FAIL rr_seq[%0d] got v=%0h pc=%0h instr=%0h want pc=%0h", i, out_valid, out_pc, out_instr, 32'h40 + 32'(i));
         end
         tick();
      end
   endtask

   task automatic test_rst_midstream();
      out_ready = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         n_cmp++; if (occupancy !== 3'(k)) begin n_err++; $display("FAIL rm_occ[%0d] got %0d want %0d", k, occupancy, k); end
         if (k < 3) tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (occupancy !== 3'd0 || out_valid !== 1'b0 || imem_addr !== 32'd0) begin
         n_err++; $display("FAIL rm_after got occ=%0d v=%0h addr=%0h want 0/0/0", occupancy, out_valid, imem_addr);
      end
      tick();
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== 32'h1000) begin
         n_err++; $display("FAIL rm_resume0 got v=%0h pc=%0h instr=%0h want 1/0/1000", out_valid, out_pc, out_instr);
      end
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'd1) begin n_err++; $display("FAIL rm_resume1 got v=%0h pc=%0h want 1/1", out_valid, out_pc); end
      tick();
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (imem_addr !== 32'hFFFF_FFFE || out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_addr got addr=%0h v=%0h want fffffffe/0", imem_addr, out_valid); end
      tick();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFE + 32'(i) || out_instr !== 32'h1000 + 32'((254 + i) % 256)) begin
            n_err++; $display("FAIL wrap_seq[%0d] got v=%0h pc=%0h instr=%0h want pc=%0h", i, out_valid, out_pc, out_instr, 32'hFFFF_FFFE + 32'(i));
         end
         tick();
      end
      // Redirect in the cycle fetch_pc is about to wrap.
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      tick();
      redirect_valid = 1'b0; out_ready = 1'b0;
      tick();
      @(negedge clk);
      n_cmp++; if (imem_addr !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap2_addr got %0h want ffffffff", imem_addr); end
      redirect_valid = 1'b1; redirect_pc = 32'h80;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (imem_addr !== 32'h80 || occupancy !== 3'd0 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL wrap2_flush got addr=%0h occ=%0d v=%0h want 80/0/0", imem_addr, occupancy, out_valid);
      end
      tick();
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h80 || out_instr !== 32'h1080) begin
         n_err++; $display("FAIL wrap2_first got v=%0h pc=%0h instr=%0h want 1/80/1080", out_valid, out_pc, out_instr);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_full();
      test_redirect_with_ready();
      test_rst_midstream();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch unit and prefetch queue between the instruction memory and the decode stage. It drives a word address to the combinational-read instruction memory every cycle and captures the returned word with its PC into a small FIFO. It presents instructions to decode over a valid/ready handshake and discards all buffered work when the fetch PC is redirected by a branch, jump, or trap.

## Interface
- ADDR_WIDTH, 32, width of PC and memory address (word address: +1 per instruction)
- DATA_WIDTH, 32, instruction width
- DEPTH, 4, queue entries; power of two, >= 2
- RESET_PC, 0, fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- imem_addr  out  ADDR_WIDTH  fetch word address, equals internal fetch_pc
- imem_data  in  DATA_WIDTH  instruction at imem_addr, valid in the same cycle (combinational memory)
- redirect_valid  in  1  load new fetch PC, flush queue
- redirect_pc  in  ADDR_WIDTH  new fetch PC
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode accepts head entry
- out_instr  out  DATA_WIDTH  head instruction
- out_pc  out  ADDR_WIDTH  word address of head instruction
- occupancy  out  $clog2(DEPTH)+1  valid entries in queue

## Operation
- State: fetch_pc, storage[DEPTH] of {pc, instr}, head/tail pointers ($clog2(DEPTH) bits, wrap modulo DEPTH), count.
- Reset values: fetch_pc=RESET_PC (so imem_addr=RESET_PC), count=0, head=tail=0, storage cleared. Outputs: out_valid=0, out_instr=0, out_pc=0, occupancy=0.
- deq = out_valid & out_ready.
- out_valid = (count != 0) & ~redirect_valid. No transfer completes in a redirect cycle.
- enq = ~redirect_valid & ((count < DEPTH) | deq). A full queue accepts a new entry in the same cycle an entry leaves.
- On enq: storage[tail] <= {fetch_pc, imem_data}; tail++; fetch_pc <= fetch_pc + 1, wrapping modulo 2^ADDR_WIDTH.
- On deq: head++.
- count updates by +enq -deq; simultaneous enq and deq leave it unchanged.
- When full and no deq: fetch_pc holds, imem_addr holds, nothing is written.
- redirect_valid (priority over everything except rst):
  - next state is count=0, head=tail=0, fetch_pc=redirect_pc;
  - the current cycle's imem_data is discarded.
- rst has priority over redirect. It restores reset values regardless of queue contents or handshake state.
- out_instr/out_pc show storage[head]. When count=0 they show stale data; the value is don't-care.
- occupancy = count.
- No other control inputs. Fetch runs continuously whenever there is space.

## Timing
- Fetch-to-queue latency: imem_addr presented in cycle N; the entry is written at the end of cycle N; out_valid is high in cycle N+1.
- After reset: with rst low in cycle R, out_valid=1, out_pc=RESET_PC in cycle R+1.
- Redirect:
  - redirect_valid in cycle N gives out_valid=0 in cycle N and N+1;
  - imem_addr=redirect_pc in cycle N+1;
  - out_valid=1, out_pc=redirect_pc in cycle N+2.
- Sustained throughput: one instruction per cycle with out_ready held high. Occupancy settles at 1.
- out_ready low for k cycles: occupancy rises by 1 per cycle and saturates at DEPTH; fetch stalls.
- After out_ready returns high: order is strictly increasing PC, with no gaps or duplicates.
- Back-pressure does not drop entries. out_instr/out_pc stay stable while out_valid=1 and out_ready=0.
- Redirect at the cycle fetch_pc wraps: the redirect wins, and the wrapped address is never enqueued.

## Test plan
- Reset, mem[i]=0x1000+i, out_ready=1: from R+1, each cycle out_pc=0,1,2,… and out_instr=0x1000,0x1001,…; occupancy=1.
- out_ready=0 for 10 cycles after the first valid:
  - occupancy reaches 4 and holds; imem_addr holds 4; out_pc holds 0;
  - then out_ready=1: out_pc sequence 0,1,2,3,4,5 with no bubble.
- Queue full, redirect_valid=1 with redirect_pc=0x20:
  - next cycle occupancy=0 and out_valid=0, imem_addr=0x20;
  - following cycle out_pc=0x20, out_instr=0x1020.
- redirect_valid and out_ready both high while count=2: out_valid=0 that cycle, no transfer; the next accepted out_pc is redirect_pc.
- rst pulsed one cycle with occupancy=3 and out_ready=0: next cycle occupancy=0, out_valid=0, imem_addr=RESET_PC; then fetch resumes from RESET_PC.
- Redirect to 0xFFFFFFFE (ADDR_WIDTH=32): out_pc sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, with instr mem[0xFE], mem[0xFF], mem[0x00].
